// File: rtl/gig_eth_mac_tx_fc.sv
// Byte-wide GMII transmit MAC: preamble/SFD, pad, CRC-32 FCS, IFG, 802.3x pause hold-off, status and stats.
// gmii_* registered one cycle behind the FSM; client is held via mac_tx_ack / pause, frame never cut by pause.
module gig_eth_mac_tx_fc #(
   parameter int PREAMBLE_BYTES  = 8,
   parameter int IFG_BYTES       = 12,
   parameter int MIN_FRAME       = 64,
   parameter int MAX_FRAME_STD   = 1522,
   parameter int MAX_FRAME_JUMBO = 9022,
   parameter int STAT_WIDTH      = 32
) (
   input  logic                  tx_clk,
   input  logic                  reset_n,
   input  logic                  conf_tx_en,
   input  logic                  conf_tx_jumbo_en,
   input  logic                  conf_tx_no_gen_crc,
   input  logic                  pause_req,
   input  logic [15:0]           pause_quanta,
   input  logic [7:0]            mac_tx_data,
   input  logic                  mac_tx_dvld,
   input  logic                  mac_tx_underrun,
   output logic                  mac_tx_ack,
   output logic [7:0]            gmii_txd,
   output logic                  gmii_txen,
   output logic                  gmii_txer,
   output logic                  tx_paused,
   output logic                  tx_status_vld,
   output logic                  tx_status_err,
   output logic [STAT_WIDTH-1:0] stat_frames_ok,
   output logic [STAT_WIDTH-1:0] stat_frames_err,
   output logic [STAT_WIDTH-1:0] stat_bytes
);
   localparam int IW = $clog2(IFG_BYTES + 1);
   localparam int PW = $clog2(PREAMBLE_BYTES);
   localparam logic [IW-1:0] IFG_LAST = IW'(IFG_BYTES - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BYTES - 1);
   localparam logic [13:0] MIN_L = 14'(MIN_FRAME);
   localparam logic [13:0] STD_L = 14'(MAX_FRAME_STD);
   localparam logic [13:0] JMB_L = 14'(MAX_FRAME_JUMBO);

   typedef enum logic [2:0] {S_IFG, S_READY, S_PRE, S_DATA, S_PAD, S_CRC, S_ERROR, S_DRAIN} state_t;

   state_t          state, state_n;
   logic [IW-1:0]   ifg_cnt, ifg_n;
   logic [PW-1:0]   pre_cnt, pre_n;
   logic [13:0]     len, len_n, min_lim, max_lim;
   logic [31:0]     crc, crc_n;
   logic [1:0]      crc_cnt, ccnt_n;
   logic [21:0]     pause_cnt, pause_n;
   logic            en_q, jumbo_q, nocrc_q, fin_q;
   logic [7:0]      txd_n;
   logic            txen_n, txer_n, ack_n, fin_now, fin_err, fin_late, pad_go, in_frame;
   logic [STAT_WIDTH-1:0] frame_bytes;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] a,
                                                      input logic [STAT_WIDTH-1:0] b);
      logic [STAT_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STAT_WIDTH] ? '1 : s[STAT_WIDTH-1:0];
   endfunction

   // Limits are in bytes handed to the CRC; with client FCS the client bytes are the whole frame.
   assign min_lim     = nocrc_q ? MIN_L : MIN_L - 14'd4;
   assign max_lim     = (jumbo_q ? JMB_L : STD_L) - (nocrc_q ? 14'd0 : 14'd4);
   assign in_frame    = state inside {S_PRE, S_DATA, S_PAD, S_CRC, S_ERROR, S_DRAIN};
   assign frame_bytes = STAT_WIDTH'(len) + (nocrc_q ? '0 : STAT_WIDTH'(4));
   assign pause_n     = pause_req ? {pause_quanta, 6'd0} :
                        (pause_cnt != 22'd0) ? pause_cnt - 22'd1 : 22'd0;

   always_comb begin
      state_n  = state;
      ifg_n    = ifg_cnt;
      pre_n    = pre_cnt;
      len_n    = len;
      crc_n    = crc;
      ccnt_n   = crc_cnt;
      txd_n    = 8'h00;
      txen_n   = 1'b0;
      txer_n   = 1'b0;
      ack_n    = 1'b0;
      fin_now  = 1'b0;
      fin_err  = 1'b0;
      fin_late = 1'b0;
      pad_go   = 1'b0;
      if (!en_q) begin
         state_n = S_IFG;
         ifg_n   = IW'(1);
         fin_now = in_frame;
         fin_err = in_frame;
      end else begin
         case (state)
            S_IFG:
               if (ifg_cnt >= IFG_LAST) state_n = S_READY;
               else ifg_n = ifg_cnt + IW'(1);
            S_READY:
               if (mac_tx_dvld && pause_cnt == 22'd0) begin
                  state_n = S_PRE;
                  pre_n   = '0;
                  len_n   = '0;
                  crc_n   = 32'hFFFFFFFF;
               end
            S_PRE: begin
               txen_n = 1'b1;
               txd_n  = (pre_cnt == PRE_LAST) ? 8'hD5 : 8'h55;
               if (mac_tx_dvld && mac_tx_underrun) state_n = S_ERROR;
               else if (pre_cnt == PRE_LAST) begin
                  state_n = S_DATA;
                  ack_n   = 1'b1;
               end else pre_n = pre_cnt + PW'(1);
            end
            S_DATA:
               if (mac_tx_dvld) begin
                  txen_n = 1'b1;
                  txd_n  = mac_tx_data;
                  len_n  = len + 14'd1;
                  crc_n  = crc_byte(crc, mac_tx_data);
                  if (mac_tx_underrun || len >= max_lim) state_n = S_ERROR;
               end else if (len < min_lim) begin
                  pad_go = 1'b1;
               end else if (nocrc_q) begin
                  // This exit cycle is already idle on the wire, so IFG is one cycle shorter.
                  state_n = S_IFG;
                  ifg_n   = IW'(2);
                  fin_now = 1'b1;
               end else begin
                  txen_n  = 1'b1;
                  txd_n   = ~crc[7:0];
                  state_n = S_CRC;
                  ccnt_n  = 2'd1;
               end
            S_PAD:
               if (mac_tx_dvld && mac_tx_underrun) begin
                  txen_n  = 1'b1;
                  state_n = S_ERROR;
               end else pad_go = 1'b1;
            S_CRC: begin
               txen_n = 1'b1;
               txd_n  = ~crc[{crc_cnt, 3'b000} +: 8];
               if (crc_cnt == 2'd3) begin
                  state_n  = S_IFG;
                  ifg_n    = IW'(1);
                  fin_late = 1'b1;
               end else ccnt_n = crc_cnt + 2'd1;
            end
            S_ERROR: begin
               txen_n  = 1'b1;
               txer_n  = 1'b1;
               state_n = S_DRAIN;
            end
            S_DRAIN:
               if (!mac_tx_dvld) begin
                  state_n = S_IFG;
                  ifg_n   = IW'(1);
                  fin_now = 1'b1;
                  fin_err = 1'b1;
               end
            default: state_n = S_IFG;
         endcase
         if (pad_go) begin
            txen_n = 1'b1;
            len_n  = len + 14'd1;
            crc_n  = crc_byte(crc, 8'h00);
            if (len + 14'd1 >= min_lim) begin
               state_n  = nocrc_q ? S_IFG : S_CRC;
               ifg_n    = IW'(1);
               ccnt_n   = 2'd0;
               fin_late = nocrc_q;
            end else state_n = S_PAD;
         end
      end
   end

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IFG;
         ifg_cnt         <= '0;
         pre_cnt         <= '0;
         len             <= '0;
         crc             <= '0;
         crc_cnt         <= '0;
         pause_cnt       <= '0;
         en_q            <= 1'b0;
         jumbo_q         <= 1'b0;
         nocrc_q         <= 1'b0;
         fin_q           <= 1'b0;
         mac_tx_ack      <= 1'b0;
         gmii_txd        <= '0;
         gmii_txen       <= 1'b0;
         gmii_txer       <= 1'b0;
         tx_paused       <= 1'b0;
         tx_status_vld   <= 1'b0;
         tx_status_err   <= 1'b0;
         stat_frames_ok  <= '0;
         stat_frames_err <= '0;
         stat_bytes      <= '0;
      end else begin
         en_q <= conf_tx_en;
         if (state == S_IFG || state == S_READY) begin
            jumbo_q <= conf_tx_jumbo_en;
            nocrc_q <= conf_tx_no_gen_crc;
         end
         state         <= state_n;
         ifg_cnt       <= ifg_n;
         pre_cnt       <= pre_n;
         len           <= len_n;
         crc           <= crc_n;
         crc_cnt       <= ccnt_n;
         pause_cnt     <= pause_n;
         tx_paused     <= (pause_n != 22'd0);
         fin_q         <= fin_late;
         mac_tx_ack    <= ack_n;
         gmii_txd      <= txd_n;
         gmii_txen     <= txen_n;
         gmii_txer     <= txer_n;
         tx_status_vld <= fin_now | fin_q;
         tx_status_err <= fin_now & fin_err;
         if (fin_now && fin_err) begin
            stat_frames_err <= sat_add(stat_frames_err, STAT_WIDTH'(1));
         end else if (fin_now || fin_q) begin
            stat_frames_ok <= sat_add(stat_frames_ok, STAT_WIDTH'(1));
            stat_bytes     <= sat_add(stat_bytes, frame_bytes);
         end
      end
   end
endmodule

// File: tb/tb_gig_eth_mac_tx_fc.sv
// Randomised frames through the TX MAC, checked against a queue-based frame/FCS/statistics model.
`timescale 1ns/1ps
module tb_gig_eth_mac_tx_fc;
   localparam int MINF = 64;

   logic        tx_clk = 1'b0, reset_n = 1'b1;
   logic        conf_tx_en = 1'b0, conf_tx_jumbo_en = 1'b0, conf_tx_no_gen_crc = 1'b0;
   logic        pause_req = 1'b0;
   logic [15:0] pause_quanta = '0;
   logic [7:0]  mac_tx_data = '0;
   logic        mac_tx_dvld = 1'b0, mac_tx_underrun = 1'b0;
   logic        mac_tx_ack, gmii_txen, gmii_txer, tx_paused, tx_status_vld, tx_status_err;
   logic [7:0]  gmii_txd;
   logic [31:0] stat_frames_ok, stat_frames_err, stat_bytes;

   gig_eth_mac_tx_fc dut (
      .tx_clk(tx_clk), .reset_n(reset_n), .conf_tx_en(conf_tx_en),
      .conf_tx_jumbo_en(conf_tx_jumbo_en), .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
      .pause_req(pause_req), .pause_quanta(pause_quanta), .mac_tx_data(mac_tx_data),
      .mac_tx_dvld(mac_tx_dvld), .mac_tx_underrun(mac_tx_underrun), .mac_tx_ack(mac_tx_ack),
      .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer), .tx_paused(tx_paused),
      .tx_status_vld(tx_status_vld), .tx_status_err(tx_status_err),
      .stat_frames_ok(stat_frames_ok), .stat_frames_err(stat_frames_err), .stat_bytes(stat_bytes)
   );

   always #4 tx_clk = ~tx_clk;

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Wire monitor: frames seen on GMII, gaps, status pulses, pause windows.
   int cyc = 0, idle_run = 0, last_gap = 0, fr_start = 0, fr_end = 0;
   int txer_cnt = 0, fr_txer = 0, st_cnt = 0, st_cyc = 0, p_rise = 0, p_fall = 0, start_paused = 0;
   logic in_fr = 1'b0, st_err = 1'b0, p_prev = 1'b0;
   logic [7:0] txer_dat = '0;
   byte unsigned cap[$], last_fr[$];

   always @(negedge tx_clk) begin
      cyc++;
      if (gmii_txen) begin
         if (!in_fr) begin
            in_fr = 1'b1;
            cap.delete();
            txer_cnt = 0;
            last_gap = idle_run;
            fr_start = cyc;
            if (tx_paused) start_paused++;
         end
         cap.push_back(gmii_txd);
         if (gmii_txer) begin
            txer_cnt++;
            txer_dat = gmii_txd;
         end
         idle_run = 0;
      end else begin
         if (in_fr) begin
            in_fr   = 1'b0;
            last_fr = cap;
            fr_txer = txer_cnt;
            fr_end  = cyc;
         end
         idle_run++;
      end
      if (tx_status_vld) begin
         st_cnt++;
         st_err = tx_status_err;
         st_cyc = cyc;
      end
      if (tx_paused && !p_prev) p_rise = cyc;
      if (!tx_paused && p_prev) p_fall = cyc;
      p_prev = tx_paused;
   end

   // Reference model
   byte unsigned fr[$], exp_q[$];
   int exp_ok = 0, exp_err = 0;
   longint exp_bytes = 0;

   function automatic logic [31:0] fcs_ref(input byte unsigned q[$]);
      logic [31:0] c, r;
      logic fb;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[31] ^ q[i][k];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
         end
      end
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return ~r;
   endfunction

   task automatic gen_frame(input int n);
      fr.delete();
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic build_exp(input logic nocrc);
      byte unsigned body[$];
      logic [31:0] f;
      int lim;
      body = fr;
      lim  = nocrc ? MINF : MINF - 4;
      while (body.size() < lim) body.push_back(8'h00);
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (body[i]) exp_q.push_back(body[i]);
      if (!nocrc) begin
         f = fcs_ref(body);
         for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
      end
      exp_ok++;
      exp_bytes += body.size() + (nocrc ? 0 : 4);
   endtask

   task automatic send_frame(input int n, input int urun_at);
      int w;
      mac_tx_dvld = 1'b1;
      mac_tx_data = fr[0];
      w = 0;
      do begin
         @(negedge tx_clk);
         w++;
      end while (!mac_tx_ack && w < 4000);
      check_eq("ack_seen", mac_tx_ack, 1'b1);
      for (int i = 1; i < n; i++) begin
         @(posedge tx_clk); #1;
         mac_tx_data     = fr[i];
         mac_tx_underrun = (i == urun_at);
      end
      @(posedge tx_clk); #1;
      mac_tx_dvld     = 1'b0;
      mac_tx_underrun = 1'b0;
      mac_tx_data     = '0;
      @(posedge tx_clk); #1;
   endtask

   task automatic wait_status(input int target);
      int w;
      w = 0;
      while (st_cnt < target && w < 20000) begin
         @(negedge tx_clk); #1;
         w++;
      end
      check_eq("status_seen", st_cnt >= target, 1'b1);
   endtask

   task automatic check_stats(input string tag);
      check_eq({tag, "_ok"}, stat_frames_ok, exp_ok);
      check_eq({tag, "_errcnt"}, stat_frames_err, exp_err);
      check_eq({tag, "_bytes"}, stat_bytes, exp_bytes);
   endtask

   task automatic check_frame(input string tag);
      int bad;
      bad = 0;
      check_eq({tag, "_len"}, last_fr.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < last_fr.size(); i++)
         if (last_fr[i] != exp_q[i]) bad++;
      check_eq({tag, "_data"}, bad, 0);
      check_eq({tag, "_txer"}, fr_txer, 0);
      check_eq({tag, "_sterr"}, st_err, 1'b0);
      check_eq({tag, "_stime"}, st_cyc, fr_end);
      check_stats(tag);
   endtask

   task automatic run_good(input string tag, input int n, input logic nocrc);
      int s0;
      gen_frame(n);
      build_exp(nocrc);
      s0 = st_cnt;
      send_frame(n, -1);
      wait_status(s0 + 1);
      check_frame(tag);
   endtask

   task automatic run_err(input string tag, input int n, input int urun_at);
      int s0;
      gen_frame(n);
      exp_err++;
      s0 = st_cnt;
      send_frame(n, urun_at);
      wait_status(s0 + 1);
      check_eq({tag, "_sterr"}, st_err, 1'b1);
      check_eq({tag, "_txer_cycles"}, fr_txer, 1);
      check_eq({tag, "_txer_data"}, txer_dat, 8'h00);
      check_stats(tag);
   endtask

   initial begin
      int s0;
      #1 reset_n = 1'b0;
      #10;
      check_eq("rst_txen", gmii_txen, 1'b0);
      check_eq("rst_txd", gmii_txd, 8'h00);
      check_eq("rst_status", tx_status_vld, 1'b0);
      check_eq("rst_paused", tx_paused, 1'b0);
      check_eq("rst_ok", stat_frames_ok, 0);
      check_eq("rst_bytes", stat_bytes, 0);
      @(posedge tx_clk); #1;
      reset_n    = 1'b1;
      conf_tx_en = 1'b1;
      repeat (20) @(posedge tx_clk);
      #1;

      run_good("f60", 60, 1'b0);
      check_eq("f60_txen_cycles", last_fr.size(), 72);
      run_good("f10", 10, 1'b0);
      check_eq("f10_txen_cycles", last_fr.size(), 72);
      for (int i = 0; i < 6; i++) run_good("rand", $urandom_range(1, 130), 1'b0);

      conf_tx_no_gen_crc = 1'b1;
      repeat (4) @(posedge tx_clk);
      #1;
      run_good("nocrc_short", 30, 1'b1);
      run_good("nocrc_long", 80, 1'b1);
      conf_tx_no_gen_crc = 1'b0;
      repeat (4) @(posedge tx_clk);
      #1;

      run_err("underrun", 40, 20);
      run_err("oversize_std", 1519, -1);
      run_good("max_std", 1518, 1'b0);
      conf_tx_jumbo_en = 1'b1;
      repeat (4) @(posedge tx_clk);
      #1;
      run_good("max_jumbo", 9018, 1'b0);
      conf_tx_jumbo_en = 1'b0;
      repeat (4) @(posedge tx_clk);
      #1;

      // back-to-back with dvld re-asserted immediately
      s0 = st_cnt;
      gen_frame(50);
      build_exp(1'b0);
      send_frame(50, -1);
      gen_frame($urandom_range(1, 100));
      build_exp(1'b0);
      send_frame(fr.size(), -1);
      wait_status(s0 + 2);
      check_frame("b2b");
      check_eq("b2b_gap", last_gap, 12);

      // pause arrives mid-frame: frame finishes, next start waits out 128 cycles
      gen_frame(60);
      build_exp(1'b0);
      s0 = st_cnt;
      fork
         send_frame(60, -1);
         begin
            repeat (30) @(posedge tx_clk);
            #1;
            pause_quanta = 16'd2;
            pause_req    = 1'b1;
            @(posedge tx_clk); #1;
            pause_req = 1'b0;
         end
      join
      wait_status(s0 + 1);
      check_frame("pause_a");
      gen_frame(20);
      build_exp(1'b0);
      s0 = st_cnt;
      send_frame(20, -1);
      wait_status(s0 + 1);
      check_frame("pause_b");
      check_eq("pause_len", p_fall - p_rise, 128);
      check_eq("pause_start", fr_start - p_fall, 2);

      // quanta=0 cancels an outstanding pause
      pause_quanta = 16'd5;
      pause_req    = 1'b1;
      @(posedge tx_clk); #1;
      pause_req = 1'b0;
      repeat (10) @(posedge tx_clk);
      #1;
      check_eq("pause_on", tx_paused, 1'b1);
      pause_quanta = 16'd0;
      pause_req    = 1'b1;
      @(posedge tx_clk); #1;
      pause_req = 1'b0;
      check_eq("pause_cancel", tx_paused, 1'b0);

      // asynchronous reset in the middle of a frame
      gen_frame(60);
      mac_tx_dvld = 1'b1;
      mac_tx_data = fr[0];
      repeat (20) @(posedge tx_clk);
      #3;
      check_eq("prerst_txen", gmii_txen, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_txen", gmii_txen, 1'b0);
      check_eq("midrst_txd", gmii_txd, 8'h00);
      check_eq("midrst_ok", stat_frames_ok, 0);
      check_eq("midrst_bytes", stat_bytes, 0);
      mac_tx_dvld = 1'b0;
      exp_ok      = 0;
      exp_err     = 0;
      exp_bytes   = 0;
      @(posedge tx_clk); #1;
      reset_n = 1'b1;
      repeat (20) @(posedge tx_clk);
      #1;
      run_good("after_rst", $urandom_range(1, 100), 1'b0);
      check_eq("start_while_paused", start_paused, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout after %0d cycles", cyc);
      $fatal(1, "watchdog");
   end
endmodule
